counter_mod: RTL and testbench
==============================

COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 SHALL have parameter WIDTH, default 4: count/data bit width, legal range 2..16.
REQ-002 SHALL have parameter MODULUS, default 10: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port load, input, 1 bit: parallel load strobe.
REQ-007 SHALL have port dir, input, 1 bit: direction, 0 = up, 1 = down.
REQ-008 SHALL have port data, input, WIDTH bits: load value.
REQ-009 SHALL have port count, output, WIDTH bits: registered count value.
REQ-010 SHALL have port sup, output, 1 bit: high while count == MODULUS-1.
REQ-011 SHALL have port inf, output, 1 bit: high while count == 0.
REQ-012 SHALL have port carry, output, 1 bit: combinational cascade flag, high when en=1, load=0 and the next edge wraps (up at MODULUS-1, or down at 0).
REQ-013 SHALL have port load_err, output, 1 bit: registered one-cycle flag for an out-of-range load.

Function
REQ-014 Each rising edge SHALL apply exactly one action, in priority order: rst, load, en, hold.
REQ-015 load=1 with data < MODULUS SHALL set count = data on that edge, regardless of en and dir.
REQ-016 load=1 with data >= MODULUS SHALL set count = MODULUS-1 and set load_err = 1 for the following cycle only.
REQ-017 load_err SHALL be 0 on every edge that is not an out-of-range load.
REQ-018 en=1, load=0, dir=0 SHALL increment count; at MODULUS-1 it SHALL wrap to 0.
REQ-019 en=1, load=0, dir=1 SHALL decrement count; at 0 it SHALL wrap to MODULUS-1.
REQ-020 en=0, load=0 SHALL hold count unchanged.
REQ-021 A dir change SHALL take effect on the next enabled edge with no dead cycle.
REQ-022 sup and inf SHALL be pure decodes of the count register, with zero latency relative to count.
REQ-023 carry SHALL depend only on count, en, load and dir, and SHALL allow cascaded stages (next stage en = carry) to form a multi-digit counter without added latency.
REQ-024 Arithmetic SHALL be performed at WIDTH bits; when MODULUS == 2**WIDTH the wrap SHALL equal natural binary overflow.
REQ-025 count SHALL never hold a value >= MODULUS after any edge.

Reset
REQ-026 rst=1 at a rising edge SHALL force count=0 and load_err=0, overriding load and en.
REQ-027 During reset, sup=0 and inf=1 follow by decode; carry SHALL be 0 while rst=1.
REQ-028 Reset asserted mid-count SHALL take effect on the very next edge with no partial update.
REQ-029 Counting SHALL resume on the first edge after rst deasserts.

Configuration
REQ-030 Macro COUNTER_MOD_SAT_EN, when defined, SHALL add input port sat (1 bit).
REQ-031 With sat=1, the counter SHALL saturate: hold at MODULUS-1 when counting up and hold at 0 when counting down, with carry forced to 0.
REQ-032 With sat=0, or with the macro undefined, the wrap behaviour of REQ-018/REQ-019 SHALL apply.
REQ-033 When the macro is undefined, the port SHALL be absent.

Verification (WIDTH=4, MODULUS=10)
REQ-034 Reset then en=1, dir=0 for 12 edges -> count 0..9, 0, 1; sup high at 9; carry high only in the cycle count=9.
REQ-035 Load data=9 with en=1, then dir=1 for 11 edges -> count 9, 8, ..., 0, 9; inf high at 0; carry high at 0.
REQ-036 load=1, data=12 -> count=9 next edge, load_err high exactly one cycle.
REQ-037 Two cascaded instances (second en = first carry), up for 100 edges -> concatenated digits read 00..99, then 00.
REQ-038 rst pulsed at count=6 with load=1, data=3 on the same edge -> count=0, load_err=0.
REQ-039 With COUNTER_MOD_SAT_EN defined and sat=1, up from 8 for 4 edges -> 9, 9, 9, 9 with carry=0; down from 1 -> 0, 0.

Source files
------------

// File: rtl/counter_mod.sv
// Modulo-MODULUS up/down counter with parallel load, range decodes and a cascade carry.
// Optional saturation mode is enabled by defining COUNTER_MOD_SAT_EN (adds input port sat).
module counter_mod #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             dir,
    input  logic [WIDTH-1:0] data,
`ifdef COUNTER_MOD_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             sup,
    output logic             inf,
    output logic             carry,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             sat_on;
    logic             at_max, at_zero, wrap, load_oor;

`ifdef COUNTER_MOD_SAT_EN
    assign sat_on = sat;
`else
    assign sat_on = 1'b0;
`endif

    assign at_max   = (count_q == MAX_VAL);
    assign at_zero  = (count_q == '0);
    assign wrap     = dir ? at_zero : at_max;
    assign load_oor = ({1'b0, data} >= MOD_EXT);

    always_comb begin
        count_d = count_q;
        err_d   = 1'b0;
        if (load) begin
            if (load_oor) begin
                count_d = MAX_VAL;
                err_d   = 1'b1;
            end else begin
                count_d = data;
            end
        end else if (en) begin
            if (wrap) begin
                // Saturation holds at the range end instead of wrapping.
                if (!sat_on) begin
                    count_d = dir ? MAX_VAL : '0;
                end
            end else begin
                count_d = dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign load_err = err_q;
    assign sup      = at_max;
    assign inf      = at_zero;
    assign carry    = !rst && en && !load && wrap && !sat_on;

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod (WIDTH=4, MODULUS=10): vector table, directed
// sequences, a two-digit cascade and randomized traffic against an arithmetic model.
module tb_counter_mod;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst, en, load, dir, sat_v;
    logic [W-1:0] data;
    logic [W-1:0] count0, count1;
    logic         sup0, inf0, carry0, err0;
    logic         sup1, inf1, carry1, err1;

    int checks   = 0;
    int failures = 0;
    int m_cnt, m_err, m_tens;

    always #5 clk = ~clk;

    counter_mod #(.WIDTH(W), .MODULUS(M)) u_units (
        .clk(clk), .rst(rst), .en(en), .load(load), .dir(dir), .data(data),
`ifdef COUNTER_MOD_SAT_EN
        .sat(sat_v),
`endif
        .count(count0), .sup(sup0), .inf(inf0), .carry(carry0), .load_err(err0)
    );

    counter_mod #(.WIDTH(W), .MODULUS(M)) u_tens (
        .clk(clk), .rst(rst), .en(carry0), .load(1'b0), .dir(dir), .data(4'd0),
`ifdef COUNTER_MOD_SAT_EN
        .sat(sat_v),
`endif
        .count(count1), .sup(sup1), .inf(inf1), .carry(carry1), .load_err(err1)
    );

    typedef struct {
        logic r, l, e, d;
        int   dat;
        int   exp_cnt;
        int   exp_err;
        int   exp_carry;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic d,
                         input int dat);
        rst  = r;
        load = l;
        en   = e;
        dir  = d;
        data = W'(dat);
    endtask

    // One clock with model-predicted expectations for both digits.
    task automatic cycle(input logic r, input logic l, input logic e, input logic d,
                         input int dat);
        int  step, exp_carry, wraps;
        step  = d ? -1 : 1;
        wraps = (m_cnt + step < 0) || (m_cnt + step >= M);
        exp_carry = (!r && e && !l && wraps && !sat_v) ? 1 : 0;
        drive(r, l, e, d, dat);
        #1;
        check("carry", int'(carry0), exp_carry);
        @(posedge clk);
        #1;
        if (r) begin
            m_cnt = 0; m_err = 0; m_tens = 0;
        end else begin
            if (exp_carry != 0) m_tens = (m_tens + M + step) % M;
            m_err = 0;
            if (l) begin
                if (dat >= M) begin m_cnt = M - 1; m_err = 1; end
                else m_cnt = dat;
            end else if (e) begin
                if (!(wraps && sat_v)) m_cnt = (m_cnt + M + step) % M;
            end
        end
        check("count", int'(count0), m_cnt);
        check("load_err", int'(err0), m_err);
        check("sup", int'(sup0), (m_cnt == M - 1) ? 1 : 0);
        check("inf", int'(inf0), (m_cnt == 0) ? 1 : 0);
        check("tens", int'(count1), m_tens);
    endtask

    vec_t vecs[12];

    initial begin
        sat_v = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        m_cnt = 0; m_err = 0; m_tens = 0;

        //          r     l     e     d     dat cnt err carry
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  0,  0,  0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6,  6,  0,  0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3,  0,  0,  0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12, 9,  1,  0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0,  0,  0,  1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0,  9,  0,  1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0,  8,  0,  0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0,  8,  0,  0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 15, 9,  1,  0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 15, 9,  1,  0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 0,  0,  0,  0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 0,  9,  0,  1};

        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].d, vecs[i].dat);
            #1;
            check($sformatf("vec%0d.carry", i), int'(carry0), vecs[i].exp_carry);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.count", i), int'(count0), vecs[i].exp_cnt);
            check($sformatf("vec%0d.load_err", i), int'(err0), vecs[i].exp_err);
            check($sformatf("vec%0d.sup", i), int'(sup0), (vecs[i].exp_cnt == M - 1) ? 1 : 0);
            check($sformatf("vec%0d.inf", i), int'(inf0), (vecs[i].exp_cnt == 0) ? 1 : 0);
        end

        // Up-count through a wrap.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
            check("up_seq", int'(count0), (i + 1) % M);
        end

        // Load 9 with en high, then count down through a wrap.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 9);
        check("load9", int'(count0), 9);
        for (int i = 0; i < 11; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 0);
            check("down_seq", int'(count0), (9 - (i + 1) + 2 * M) % M);
        end

        // Out-of-range load flags exactly one cycle.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 12);
        check("oor_cnt", int'(count0), 9);
        check("oor_err", int'(err0), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("oor_err_clr", int'(err0), 0);

        // Two-digit cascade 00..99 then 00.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 100; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
            check("cascade", int'(count1) * 10 + int'(count0), i % 100);
        end

        // Reset wins over a simultaneous load, counting resumes right after.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 6);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 3);
        check("rst_over_load", int'(count0), 0);
        check("rst_err", int'(err0), 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
        check("resume", int'(count0), 1);

`ifdef COUNTER_MOD_SAT_EN
        sat_v = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
            check("sat_up", int'(count0), 9);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 0);
            check("sat_dn", int'(count0), 0);
        end
        sat_v = 1'b0;
`endif

        // Randomized traffic with direction runs so the tens digit also moves.
        begin
            logic rd;
            rd = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) rd = ~rd;
                cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) != 0), rd, int'($urandom_range(0, 15)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
